// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator / MAC datapath.
package product_accumulator_pkg;

  // Widest accumulator any client is expected to build; saturation
  // constants are produced at this width and sliced by the user.
  localparam int MAX_ACC_W = 128;

  typedef logic [MAX_ACC_W-1:0] wide_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Accumulator width: full product plus guard bits.
  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

  // Largest positive value of a w-bit two's complement number.
  function automatic wide_t acc_max(input int w);
    return (wide_t'(1) << (w - 1)) - wide_t'(1);
  endfunction

  // Most negative value of a w-bit two's complement number (low w bits).
  function automatic wide_t acc_min(input int w);
    return wide_t'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// W-bit signed adder that clamps to the representable range on overflow.
module product_accumulator_sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int W = 72
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam wide_t          MAX_WIDE = acc_max(W);
  localparam wide_t          MIN_WIDE = acc_min(W);
  localparam logic [W-1:0]   SAT_MAX  = MAX_WIDE[W-1:0];
  localparam logic [W-1:0]   SAT_MIN  = MIN_WIDE[W-1:0];

  logic [W-1:0] raw;

  // Overflow only when both operands share a sign the result does not.
  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    if (ovf) begin
      sum = a[W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = raw;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Streaming signed frame accumulator fed by the registered tree multiplier.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int GUARD = 8,
  parameter  int CNT_W = 16,
  localparam int ACC_W = acc_width(N, GUARD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [2*N-1:0]     prod_in,
  input  logic               prod_valid,
  input  logic               prod_last,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   sum_out,
  output logic [CNT_W-1:0]   term_count,
  output logic               ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t             state;
  state_t             state_next;
  logic               in_fire;
  logic               out_fire;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               ovf_acc;
  logic               ovf_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  assign prod_ext = {{GUARD{prod_in[2*N-1]}}, prod_in};

  product_accumulator_sat_adder #(.W(ACC_W)) u_sat_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: frames advance only on handshakes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          state_next = prod_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (in_fire && prod_last) begin
          state_next = ST_HOLD;
        end else begin
          state_next = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake decode; ready is withheld during reset and while a result is pending.
  always_comb begin
    if (!reset && enable && (state != ST_HOLD)) begin
      prod_ready = 1'b1;
    end else begin
      prod_ready = 1'b0;
    end
    in_fire  = prod_valid & prod_ready;
    out_fire = out_valid & out_ready & enable & (state == ST_HOLD);
  end

  // Post-update accumulator values; a saturated sum is frozen for the frame.
  always_comb begin
    if (ovf_acc) begin
      acc_next = acc;
    end else begin
      acc_next = add_sum;
    end
    ovf_next = ovf_acc | add_ovf;
    if (cnt == {CNT_W{1'b1}}) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Accumulator and result registers; the frame's last term lands in the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      sum_out    <= '0;
      term_count <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
    end else if (in_fire) begin
      if (prod_last) begin
        acc        <= '0;
        cnt        <= '0;
        ovf_acc    <= 1'b0;
        sum_out    <= acc_next;
        term_count <= cnt_next;
        ovf        <= ovf_next;
        out_valid  <= 1'b1;
      end else begin
        acc        <= acc_next;
        cnt        <= cnt_next;
        ovf_acc    <= ovf_next;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized checks of product_accumulator against a frame-level model.
module tb_product_accumulator;

  localparam int N     = 32;
  localparam int GUARD = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 2 * N + GUARD;

  localparam logic signed [127:0] MAXV = (128'sd1 <<< (ACC_W - 1)) - 128'sd1;
  localparam logic signed [127:0] MINV = -(128'sd1 <<< (ACC_W - 1));

  logic               clk;
  logic               reset;
  logic               enable;
  logic [2*N-1:0]     prod_in;
  logic               prod_valid;
  logic               prod_last;
  logic               prod_ready;
  logic [ACC_W-1:0]   sum_out;
  logic [CNT_W-1:0]   term_count;
  logic               ovf;
  logic               out_valid;
  logic               out_ready;

  int total = 0;
  int bad   = 0;
  logic signed [63:0] frame_q[$];

  product_accumulator #(.N(N), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .sum_out    (sum_out),
    .term_count (term_count),
    .ovf        (ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame result from exact integer arithmetic with clamping and sticky saturation.
  function automatic void model_frame(input logic signed [63:0] q[$],
                                      output logic [ACC_W-1:0] s,
                                      output logic [CNT_W-1:0] c,
                                      output logic o);
    logic signed [127:0] a;
    a = 128'sd0;
    o = 1'b0;
    foreach (q[i]) begin
      if (!o) begin
        a = a + 128'(q[i]);
        if (a > MAXV) begin
          a = MAXV; o = 1'b1;
        end else if (a < MINV) begin
          a = MINV; o = 1'b1;
        end
      end
    end
    s = a[ACC_W-1:0];
    c = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
  endfunction

  // Offer one product at a negedge; returns at the negedge after it is taken.
  task automatic send(input logic [63:0] v, input logic last);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod_in    = v;
    prod_last  = last;
    #1;
    while (!prod_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", 128'(n), 128'd0);
    @(negedge clk);
    frame_q.push_back(v);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Wait for the result, compare with the model, then hand it off.
  task automatic collect(input string tag);
    logic [ACC_W-1:0] s;
    logic [CNT_W-1:0] c;
    logic             o;
    int               n;
    model_frame(frame_q, s, c, o);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'd1);
    check({tag, "_sum"},   128'(sum_out),   128'(s));
    check({tag, "_cnt"},   128'(term_count), 128'(c));
    check({tag, "_ovf"},   128'(ovf),       128'(o));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    frame_q.delete();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; prod_in = '0; prod_valid = 1'b0;
    prod_last = 1'b0; out_ready = 1'b0;

    // Reset behaviour
    @(negedge clk);
    check("rst_ready_low", 128'(prod_ready), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_sum",   128'(sum_out),   128'd0);
    check("rst_cnt",   128'(term_count), 128'd0);
    check("rst_ovf",   128'(ovf),       128'd0);
    check("rst_ready", 128'(prod_ready), 128'd1);

    // Basic frame {5,-3,10}
    send(64'd5, 1'b0);
    send(-64'sd3, 1'b0);
    send(64'd10, 1'b1);
    check("basic_latency", 128'(out_valid), 128'd1);
    check("basic_sum_const", 128'(sum_out), 128'd12);
    collect("basic");
    check("basic_one_cycle", 128'(out_valid), 128'd0);

    // Single negative term, fully sign-extended
    send(-64'sd7, 1'b1);
    check("single_sum_const", 128'(sum_out), 128'({ACC_W{1'b1}} - 72'd6));
    collect("single");

    // Backpressure while a product waits
    send(64'd1, 1'b0);
    send(64'd2, 1'b1);
    frame_q.delete();
    prod_valid = 1'b1; prod_in = 64'd77; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready",  128'(prod_ready), 128'd0);
      check("bp_valid",  128'(out_valid),  128'd1);
      check("bp_sum",    128'(sum_out),    128'd3);
      check("bp_cnt",    128'(term_count), 128'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("bp_idle_valid", 128'(out_valid),  128'd0);
    check("bp_idle_ready", 128'(prod_ready), 128'd1);
    @(negedge clk);
    frame_q.push_back(64'sd77);
    prod_valid = 1'b0; prod_last = 1'b0;
    collect("bp_pending");

    // Positive saturation: 600 x 2^62
    for (int i = 0; i < 600; i++) send(64'h4000_0000_0000_0000, (i == 599));
    check("ovf_sum_const", 128'(sum_out), 128'(MAXV));
    check("ovf_flag_const", 128'(ovf), 128'd1);
    collect("ovf_pos");
    send(64'd3, 1'b1);
    collect("ovf_clear");

    // Negative saturation followed by positive terms that must not pull it back
    for (int i = 0; i < 520; i++) send(64'hC000_0000_0000_0000, 1'b0);
    send(64'd1000, 1'b1);
    collect("ovf_neg");

    // Reset mid-frame discards the partial sum
    send(64'd100, 1'b0);
    send(64'd200, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_ready", 128'(prod_ready), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    frame_q.delete();
    check("midrst_sum", 128'(sum_out), 128'd0);
    send(64'd1, 1'b1);
    collect("midrst");

    // Enable low mid-frame and in HOLD
    send(64'd10, 1'b0);
    prod_valid = 1'b1; prod_in = 64'd20; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_ready", 128'(prod_ready), 128'd0);
      @(negedge clk);
    end
    enable = 1'b1;
    send(64'd20, 1'b0);
    send(64'd30, 1'b1);
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_hold_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    out_ready = 1'b0; enable = 1'b1;
    check("en_sum_const", 128'(sum_out), 128'd60);
    collect("enable");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) send({$urandom, $urandom}, (i == len - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      collect("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Streaming signed accumulator that sits directly downstream of the registered tree multiplier. It consumes 2N-bit signed products one per cycle, with a valid/ready handshake and a frame-end marker. Each frame is summed into a guard-extended saturating accumulator. At frame end it presents the sum, a term count and an overflow flag on a held output handshake. Together with the multiplier this forms a dot-product / MAC datapath.

## Interface
Parameters:
- N, 32, multiplier operand width; products are 2N bits.
- GUARD, 8, extra accumulator bits; ACC_W = 2N+GUARD.
- CNT_W, 16, term-counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  global advance; low freezes all state.
- prod_in  in  2N  signed product (two's complement).
- prod_valid  in  1  prod_in is valid this cycle.
- prod_last  in  1  qualifies with prod_valid; this product ends the frame.
- prod_ready  out  1  block can accept a product this cycle.
- sum_out  out  ACC_W  signed frame sum.
- term_count  out  CNT_W  number of products in the frame.
- ovf  out  1  frame sum saturated.
- out_valid  out  1  sum_out/term_count/ovf valid.
- out_ready  in  1  consumer accepts the result.

## Operation
- Transfer in: prod_valid & prod_ready & enable. Transfer out: out_valid & out_ready & enable.
- States:
  - IDLE: acc=0, cnt=0, ovf=0.
  - ACCUM: at least one term accepted.
  - HOLD: result presented.
- Transitions:
  - IDLE→ACCUM on a transfer-in without last.
  - IDLE→HOLD on a transfer-in with last (single-term frame).
  - ACCUM→HOLD on a transfer-in with last.
  - HOLD→IDLE on transfer-out.
- prod_ready = enable & (state != HOLD). No input is accepted in HOLD, so there is one bubble cycle per frame.
- Accumulate:
  - Sign-extend prod_in to ACC_W, then add to acc.
  - Signed overflow occurs when both operands have the same sign and the result has the opposite sign. On overflow, acc saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) by operand sign, and ovf is set.
  - Once ovf is set, acc holds its saturated value for the rest of the frame. Further terms are still accepted and counted.
- cnt increments per accepted term and saturates at 2^CNT_W-1 (no wrap).
- The term with prod_last is included in the sum. On entering HOLD, sum_out/term_count/ovf are the post-update values.
- Frames are never empty. prod_last without prod_valid is ignored.
- enable=0: no transfers, no state change, outputs hold. out_valid stays asserted if already in HOLD.
- prod_valid may be asserted in HOLD. The producer holds prod_in until prod_ready.

## Timing
- Reset values: prod_ready=0 during the reset cycle, then 1 once in IDLE with enable=1. sum_out=0, term_count=0, ovf=0, out_valid=0.
- Reset mid-frame or mid-HOLD discards the partial or pending result. The state is IDLE on the next cycle.
- Latency: last product accepted at edge t → out_valid=1 from t+1.
- End to end from multiplier operands: 2 register stages in the multiplier plus 1 here.
- Outputs are registered. They are stable throughout HOLD, independent of out_ready.
- Transfer-out at edge t → IDLE at t+1, prod_ready=1 at t+1. Minimum frame period is terms+1 cycles.
- Throughput inside a frame: 1 product/cycle.

## Structure
- Shared package:
  - ACC_W derivation.
  - State enum {IDLE, ACCUM, HOLD}.
  - Saturation constants ACC_MAX and ACC_MIN as functions of ACC_W.
- Sub-module sat_adder: ACC_W signed add with saturation and an ovf output. Combinational, reused by later MAC blocks.
- Top holds the FSM, acc, cnt and ovf registers, and the output registers.

## Test plan
- Frame {5, -3, 10(last)} with out_ready=1:
  - sum_out=12, term_count=3, ovf=0.
  - out_valid for 1 cycle, 1 cycle after the last transfer.
- Single-term frame {-7(last)}: sum_out=-7 (all ACC_W bits sign-extended), term_count=1.
- Backpressure:
  - Complete a frame, then hold out_ready=0 for 5 cycles while prod_valid=1.
  - Required: prod_ready=0, outputs stable, no input consumed.
  - out_ready=1 → IDLE the next cycle; the pending product is accepted the cycle after.
- Overflow (N=32, GUARD=8): 600 terms of +2^62, last on the 600th.
  - Saturation occurs at term 512.
  - Required: sum_out=2^71-1, ovf=1, term_count=600.
  - Next frame starts with ovf=0.
- Reset mid-frame:
  - Accept {100, 200}, assert reset 1 cycle, then send frame {1(last)}.
  - Required: sum_out=1, term_count=1.
- enable low:
  - Drop enable for 3 cycles mid-frame and during HOLD.
  - Required: no acceptance, no count change, out_valid held.
  - Final sum matches the enable=1 run.
